// File: rtl/fifo_hash_sequencer.sv
// Read-side FNV-1a-32 sequencer: drains a fall-through byte FIFO and presents the digest via valid/ready.
// Optional byte counter enabled by defining FNV_BYTE_COUNT_EN.
module fifo_hash_sequencer #(
  parameter logic [31:0] OFFSET_BASIS = 32'h811C9DC5,
  parameter logic [31:0] FNV_PRIME    = 32'h01000193
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fifo_rempty,
  input  logic [7:0]  fifo_rdata,
  output logic        fifo_rinc,
  input  logic        start,
  input  logic        finalize,
  output logic [31:0] hash_out,
  output logic        hash_valid,
  input  logic        hash_ready,
`ifdef FNV_BYTE_COUNT_EN
  output logic        busy,
  output logic [15:0] byte_count
`else
  output logic        busy
`endif
);

  // state | meaning
  // IDLE  | hash held at basis, waiting for start
  // DRAIN | pop a byte if available, else close message when fin_pend
  // MIX   | multiply step of FNV-1a for the byte just popped
  // DONE  | digest valid, waiting for hash_ready
  typedef enum logic [1:0] {IDLE, DRAIN, MIX, DONE} state_t;

  state_t      state;
  logic [31:0] hash;
  logic [31:0] x;
  logic [31:0] mix_val;
  logic        fin_pend;

  assign mix_val   = x * FNV_PRIME;
  assign fifo_rinc = (state == DRAIN) && !fifo_rempty;
  assign hash_out  = hash;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      hash       <= OFFSET_BASIS;
      x          <= 32'd0;
      fin_pend   <= 1'b0;
      hash_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          hash <= OFFSET_BASIS;
          if (start) begin
            state <= DRAIN;
            busy  <= 1'b1;
          end
        end
        DRAIN: begin
          if (finalize) fin_pend <= 1'b1;
          if (!fifo_rempty) begin
            x     <= hash ^ {24'b0, fifo_rdata};
            state <= MIX;
          end else if (fin_pend) begin
            // clearing here overrides a same-cycle finalize set above
            fin_pend   <= 1'b0;
            state      <= DONE;
            hash_valid <= 1'b1;
            busy       <= 1'b0;
          end
        end
        MIX: begin
          if (finalize) fin_pend <= 1'b1;
          hash  <= mix_val;
          state <= DRAIN;
        end
        DONE: begin
          if (hash_ready) begin
            state      <= IDLE;
            hash_valid <= 1'b0;
            hash       <= OFFSET_BASIS;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FNV_BYTE_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_count <= 16'd0;
    end else if (state == IDLE && start) begin
      byte_count <= 16'd0;
    end else if (fifo_rinc && byte_count != 16'hFFFF) begin
      byte_count <= byte_count + 16'd1;
    end
  end
`endif

endmodule
